// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one full-adder stage with a registered carry,
// LSB-first, one bit per clock, result published with a one-cycle done pulse.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_a_sh;
  logic [WIDTH-1:0] r_b_sh;
  logic [WIDTH-1:0] r_r_sh;
  logic             r_carry;
  logic [CW-1:0]    r_cnt;

  logic             w_bit;
  logic             w_carry;
  logic [WIDTH-1:0] w_r_next;
  logic             w_last;

  // One-bit full-adder stage fed from the operand LSBs and the carry loop.
  assign w_bit   = r_a_sh[0] ^ r_b_sh[0] ^ r_carry;
  assign w_carry = (r_a_sh[0] & r_b_sh[0]) | (r_b_sh[0] & r_carry) | (r_carry & r_a_sh[0]);
  assign w_last  = (r_cnt == CW'(WIDTH - 1));

  generate
    if (WIDTH == 1) begin : g_r_one
      assign w_r_next = w_bit;
    end else begin : g_r_multi
      assign w_r_next = {w_bit, r_r_sh[WIDTH-1:1]};
    end
  endgenerate

  // NOTE: every register here, datapath included, is cleared by rst_n so a
  // reset mid-operation leaves no stale partial result behind.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_a_sh  <= '0;
      r_b_sh  <= '0;
      r_r_sh  <= '0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      sum     <= '0;
      cout    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge
      // values; the shift, carry and completion logic depend on that.
      done <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (start) begin
            r_a_sh  <= a;
            r_b_sh  <= b;
            r_carry <= cin;
            r_cnt   <= '0;
            busy    <= 1'b1;
            r_state <= RUN;
          end
        end
        RUN: begin
          r_a_sh  <= r_a_sh >> 1;
          r_b_sh  <= r_b_sh >> 1;
          r_r_sh  <= w_r_next;
          r_carry <= w_carry;
          r_cnt   <= r_cnt + CW'(1);
          if (w_last) begin
            sum     <= w_r_next;
            cout    <= w_carry;
            done    <= 1'b1;
            busy    <= 1'b0;
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: vector table, random operands against
// an arithmetic model, and hand-written busy/back-to-back/reset sequences.
module tb_serial_adder;

  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;

  int checks   = 0;
  int failures = 0;

  serial_adder #(.WIDTH(W)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .start(start),
    .a    (a),
    .b    (b),
    .cin  (cin),
    .busy (busy),
    .done (done),
    .sum  (sum),
    .cout (cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] va;
    logic [W-1:0] vb;
    logic         vc;
    logic [W-1:0] exp_sum;
    logic         exp_cout;
  } vec_t;

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h", nm, got, exp);
    end
  endtask

  // Issue one operation from IDLE and verify handshake timing and result.
  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb2,
                        input logic tc, input string nm);
    logic [W:0] ex;
    int lat;
    int busy_cnt;
    ex = {1'b0, ta} + {1'b0, tb2} + {{W{1'b0}}, tc};
    @(negedge clk);
    start = 1'b1; a = ta; b = tb2; cin = tc;
    @(negedge clk);
    start = 1'b0; a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
    lat = 0;
    busy_cnt = 0;
    while (!done && lat < W + 4) begin
      if (busy) busy_cnt++;
      @(negedge clk);
      lat++;
    end
    check({nm, " done"}, 32'(done), 32'd1);
    check({nm, " latency"}, 32'(lat), 32'(W));
    check({nm, " busy_cycles"}, 32'(busy_cnt), 32'(W));
    check({nm, " busy_in_done"}, 32'(busy), 32'd0);
    check({nm, " sum"}, 32'(sum), 32'(ex[W-1:0]));
    check({nm, " cout"}, 32'(cout), 32'(ex[W]));
    @(negedge clk);
    check({nm, " done_1cyc"}, 32'(done), 32'd0);
  endtask

  initial begin
    vec_t vecs[5];
    int done_cnt;
    int bad;
    int pulse_q[$];
    logic [W:0] ex;

    vecs[0] = '{8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0};
    vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
    vecs[2] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
    vecs[3] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
    vecs[4] = '{8'h10, 8'h20, 1'b1, 8'h31, 1'b0};

    // Reset with inputs toggling.
    rst_n = 1'b0; start = 1'b0; a = '0; b = '0; cin = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      start = 1'($urandom); a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
    end
    check("rst busy", 32'(busy), 32'd0);
    check("rst done", 32'(done), 32'd0);
    check("rst sum", 32'(sum), 32'd0);
    check("rst cout", 32'(cout), 32'd0);
    start = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      a = W'($urandom); b = W'($urandom);
      if (busy || done || sum != '0) bad++;
    end
    check("idle_after_rst", 32'(bad), 32'd0);

    // Vector table: both the table's constants and the arithmetic model apply.
    for (int i = 0; i < 5; i++) begin
      ex = {1'b0, vecs[i].va} + {1'b0, vecs[i].vb} + {{W{1'b0}}, vecs[i].vc};
      check($sformatf("vec%0d table", i), 32'(ex), 32'({vecs[i].exp_cout, vecs[i].exp_sum}));
      run_op(vecs[i].va, vecs[i].vb, vecs[i].vc, $sformatf("vec%0d", i));
    end

    // Random operands against plain addition.
    for (int i = 0; i < 30; i++)
      run_op(W'($urandom), W'($urandom), 1'($urandom), $sformatf("rnd%0d", i));

    // Start and operand changes while busy must be ignored.
    @(negedge clk);
    start = 1'b1; a = 8'h5A; b = 8'h3C; cin = 1'b0;
    done_cnt = 0;
    for (int i = 0; i < 2 * W + 4; i++) begin
      @(negedge clk);
      if (done) done_cnt++;
      if (i < W - 1) begin
        start = 1'b1; a = 8'h01 + W'(i); b = 8'h01 ^ W'(i * 3); cin = 1'($urandom);
      end else begin
        start = 1'b0;
      end
    end
    check("busy_ignore done_count", 32'(done_cnt), 32'd1);
    check("busy_ignore sum", 32'(sum), 32'h96);
    check("busy_ignore cout", 32'(cout), 32'd0);

    // Continuous start: back-to-back results, one done cycle between runs.
    @(negedge clk);
    start = 1'b1; a = 8'h10; b = 8'h20; cin = 1'b1;
    bad = 0;
    for (int c = 0; c < 4 * (W + 1) + 2; c++) begin
      @(negedge clk);
      if (done) begin
        pulse_q.push_back(c);
        if (sum != 8'h31 || cout != 1'b0) bad++;
      end
      if (pulse_q.size() > 0 && sum != 8'h31) bad++;
    end
    start = 1'b0;
    check("b2b pulses", 32'(pulse_q.size() >= 3), 32'd1);
    check("b2b first_latency", 32'(pulse_q.size() > 0 ? pulse_q[0] : -1), 32'(W));
    for (int k = 1; k < pulse_q.size(); k++)
      check($sformatf("b2b period%0d", k), 32'(pulse_q[k] - pulse_q[k-1]), 32'(W + 1));
    check("b2b sum_hold", 32'(bad), 32'd0);
    repeat (W + 3) @(negedge clk);

    // Reset mid-operation.
    check("pre_rst sum", 32'(sum), 32'h31);
    start = 1'b1; a = 8'hAA; b = 8'h55; cin = 1'b0;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    check("midrun busy", 32'(busy), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst busy", 32'(busy), 32'd0);
    check("async_rst sum", 32'(sum), 32'd0);
    check("async_rst cout", 32'(cout), 32'd0);
    check("async_rst done", 32'(done), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    done_cnt = 0;
    for (int i = 0; i < W + 3; i++) begin
      @(negedge clk);
      if (done || busy) done_cnt++;
    end
    check("post_rst no_activity", 32'(done_cnt), 32'd0);
    run_op(8'h01, 8'h02, 1'b0, "restart");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
